// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one booth_top multiplier between NREQ requesters.
// A round-robin arbiter picks one pending requester, the block latches its operands,
// writes them into the multiplier, holds start until done (or timeout), returns the
// product to that requester only, then waits for done to clear before the next job.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset
//   req_valid_i   per-requester job pending, held until req_ready_o
//   req_a_i       operand A of requester i at [i*W +: W]
//   req_b_i       operand B of requester i at [i*W +: W]
//   req_ready_o   one-hot grant, operands captured on this cycle
//   rsp_valid_o   one-hot 1-cycle completion pulse
//   rsp_result_o  2*W product, valid with rsp_valid_o
//   rsp_err_o     timeout flag, valid with rsp_valid_o
//   busy_o        high whenever a job is in flight
//   mul_a_o       to booth_top.A
//   mul_b_o       to booth_top.B
//   mul_awrite_o  to booth_top.Awrite
//   mul_bwrite_o  to booth_top.Bwrite
//   mul_start_o   to booth_top.start (level)
//   mul_done_i    from booth_top.done (level or pulse)
//   mul_result_i  from booth_top.Result
module booth_mul_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned LOAD_CYC = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*W-1:0] req_a_i,
  input  logic [NREQ*W-1:0] req_b_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [2*W-1:0]    rsp_result_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic [W-1:0]      mul_a_o,
  output logic [W-1:0]      mul_b_o,
  output logic              mul_awrite_o,
  output logic              mul_bwrite_o,
  output logic              mul_start_o,
  input  logic              mul_done_i,
  input  logic [2*W-1:0]    mul_result_i
);

  localparam int unsigned IdxW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntMax = (TIMEOUT > LOAD_CYC) ? TIMEOUT : LOAD_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] LoadLast    = CntW'(LOAD_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StResp, StClear} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [2*W-1:0]    result_q, result_d;
  logic              err_q, err_d;

  logic              gnt_found;
  logic [IdxW-1:0]   gnt_idx;

  // Round-robin pick: first valid index after rr_ptr_q, wrapping modulo NREQ.
  // Grants are suppressed while reset is asserted so a grant is never lost.
  always_comb begin : p_arb
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = (int'(rr_ptr_q) + off) % NREQ;
      if (!gnt_found && req_valid_i[IdxW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(cand);
      end
    end
    if (rst_i || state_q != StIdle) begin
      gnt_found = 1'b0;
    end
  end

  always_comb begin : p_next
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          a_d      = req_a_i[gnt_idx*W +: W];
          b_d      = req_b_i[gnt_idx*W +: W];
          rr_ptr_d = gnt_idx;
          owner_d  = gnt_idx;
          cnt_d    = '0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (cnt_q == LoadLast) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        // done has priority over a coincident timeout
        if (mul_done_i) begin
          result_d = mul_result_i;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = StResp;
        end else if (cnt_q == TimeoutLast) begin
          result_d = '0;
          err_d    = 1'b1;
          cnt_d    = '0;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StClear;
      end
      StClear: begin
        // A level-held done must drop before the next job can start.
        if (!mul_done_i || cnt_q == TimeoutLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rr_ptr_q <= IdxW'(NREQ - 1);
      owner_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin : p_out
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (gnt_found) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
    if (state_q == StResp) begin
      rsp_valid_o[owner_q] = 1'b1;
    end
    busy_o       = (state_q != StIdle);
    rsp_result_o = (state_q == StResp) ? result_q : '0;
    rsp_err_o    = (state_q == StResp) && err_q;
    mul_a_o      = busy_o ? a_q : '0;
    mul_b_o      = busy_o ? b_q : '0;
    mul_awrite_o = (state_q == StLoad);
    mul_bwrite_o = (state_q == StLoad);
    mul_start_o  = (state_q == StRun);
  end

endmodule
